dmi_boot_sequencer: RTL

Synthesisable successor to the bench-only JTAG boot flow. It drives the debug module's DMI request/response port directly to boot harts: activate the DM, then for each enabled hart halt it, write DPC through an abstract command, and resume it. It is generalised to NrHarts harts, runtime per-hart boot addresses, XLEN 32/64, and adds busy-retry, timeout and cmderr recovery. It sits between SoC boot control and the dm_top DMI slave, muxed with the JTAG DTM.

---
 rtl/dmi_boot_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmi_boot_sequencer.sv
// Boots harts over the debug module's DMI port: activate the DM, then per enabled hart
// halt, write DPC via an abstract command, and resume. Handles busy retry, poll timeout, cmderr.
module dmi_boot_sequencer #(
    parameter int unsigned NrHarts      = 1,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned PollTimeout  = 1024,
    parameter int unsigned MaxBusyRetry = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [NrHarts-1:0]      hart_mask_i,
    input  logic [NrHarts*XLEN-1:0] boot_addr_i,
    output logic                    dmi_req_valid_o,
    input  logic                    dmi_req_ready_i,
    output logic [6:0]              dmi_req_addr_o,
    output logic [1:0]              dmi_req_op_o,
    output logic [31:0]             dmi_req_data_o,
    input  logic                    dmi_resp_valid_i,
    output logic                    dmi_resp_ready_o,
    input  logic [31:0]             dmi_resp_data_i,
    input  logic [1:0]              dmi_resp_code_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [9:0]              err_hart_o,
    output logic [2:0]              err_code_o
);

    localparam int unsigned HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
    localparam int unsigned PollW = $clog2(PollTimeout + 1);
    localparam int unsigned BusyW = $clog2(MaxBusyRetry + 1);
    localparam logic [31:0] AarSize = (XLEN == 64) ? 32'd3 : 32'd2;
    localparam logic [31:0] CmdWord = (32'd1 << 17) | (32'd1 << 16) | (AarSize << 20) | 32'h7B1;
    localparam logic [1:0]  OpRead  = 2'd1;
    localparam logic [1:0]  OpWrite = 2'd2;

    typedef enum logic [3:0] {
        StIdle, StActivate, StSel, StHalt, StPollHalt, StWrD0, StWrD1, StWrCmd,
        StPollCmd, StClrErr, StResume, StPollRes, StDone, StError
    } state_e;

    typedef enum logic [1:0] {PhLaunch, PhReq, PhResp} phase_e;

    state_e                  state_q;
    phase_e                  phase_q;
    logic [NrHarts-1:0]      mask_q;
    logic [NrHarts*XLEN-1:0] addr_q;
    logic [HartW-1:0]        hart_q;
    logic [PollW-1:0]        poll_cnt_q;
    logic [BusyW-1:0]        busy_cnt_q;
    logic                    req_valid_q, resp_ready_q, busy_q, done_q, error_q;
    logic [6:0]              req_addr_q;
    logic [1:0]              req_op_q;
    logic [31:0]             req_data_q;
    logic [9:0]              err_hart_q;
    logic [2:0]              err_code_q;

    logic [63:0]      dpc;
    logic [31:0]      hartsel;
    logic [6:0]       cmd_addr;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_data;
    logic             sel_any;
    logic [HartW-1:0] sel_idx;
    logic [2:0]       fail_code;
    state_e           adv_state;
    logic             reissue, poll_retry, poll_expired;

    assign dpc     = 64'(addr_q[32'(hart_q) * XLEN +: XLEN]);
    assign hartsel = 32'(hart_q) << 16;
    assign sel_any = |mask_q;
    assign poll_expired = (poll_cnt_q == PollW'(PollTimeout - 1));

    always_comb begin
        sel_idx = '0;
        for (int i = NrHarts - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_idx = HartW'(i);
        end
    end

    // Request contents are a pure function of the current state and hart.
    always_comb begin
        cmd_addr = 7'h00;
        cmd_op   = OpWrite;
        cmd_data = 32'h0;
        case (state_q)
            StActivate: begin cmd_addr = 7'h10; cmd_data = 32'h1; end
            StHalt:     begin cmd_addr = 7'h10; cmd_data = 32'h8000_0001 | hartsel; end
            StPollHalt, StPollRes: begin cmd_addr = 7'h11; cmd_op = OpRead; end
            StWrD0:     begin cmd_addr = 7'h04; cmd_data = dpc[31:0]; end
            StWrD1:     begin cmd_addr = 7'h05; cmd_data = dpc[63:32]; end
            StWrCmd:    begin cmd_addr = 7'h17; cmd_data = CmdWord; end
            StPollCmd:  begin cmd_addr = 7'h16; cmd_op = OpRead; end
            StClrErr:   begin cmd_addr = 7'h16; cmd_data = 32'h700; end
            StResume:   begin cmd_addr = 7'h10; cmd_data = 32'h4000_0001 | hartsel; end
            default:    cmd_op = 2'd0;
        endcase
    end

    // Outcome of the response currently presented; only acted on during the handshake.
    always_comb begin
        fail_code  = 3'd0;
        adv_state  = state_q;
        reissue    = 1'b0;
        poll_retry = 1'b0;
        if (dmi_resp_code_i == 2'd3) begin
            if (busy_cnt_q == BusyW'(MaxBusyRetry - 1)) fail_code = 3'd6;
            else reissue = 1'b1;
        end else if (dmi_resp_code_i != 2'd0) begin
            fail_code = 3'd5;
        end else begin
            case (state_q)
                StActivate: adv_state = StSel;
                StHalt:     adv_state = StPollHalt;
                StPollHalt: begin
                    if (dmi_resp_data_i[9]) adv_state = StWrD0;
                    else if (poll_expired)  fail_code = 3'd1;
                    else                    poll_retry = 1'b1;
                end
                StWrD0:     adv_state = (XLEN == 64) ? StWrD1 : StWrCmd;
                StWrD1:     adv_state = StWrCmd;
                StWrCmd:    adv_state = StPollCmd;
                StPollCmd: begin
                    if (!dmi_resp_data_i[12]) begin
                        adv_state = (dmi_resp_data_i[10:8] != 3'd0) ? StClrErr : StResume;
                    end else if (poll_expired) begin
                        fail_code = 3'd3;
                    end else begin
                        poll_retry = 1'b1;
                    end
                end
                StClrErr:   fail_code = 3'd2;
                StResume:   adv_state = StPollRes;
                StPollRes: begin
                    if (dmi_resp_data_i[17]) adv_state = StSel;
                    else if (poll_expired)   fail_code = 3'd4;
                    else                     poll_retry = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            phase_q      <= PhLaunch;
            mask_q       <= '0;
            addr_q       <= '0;
            hart_q       <= '0;
            poll_cnt_q   <= '0;
            busy_cnt_q   <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_op_q     <= '0;
            req_data_q   <= '0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_hart_q   <= '0;
            err_code_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (start_i) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_hart_q <= '0;
                        err_code_q <= '0;
                        mask_q     <= hart_mask_i;
                        addr_q     <= boot_addr_i;
                        hart_q     <= '0;
                        busy_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StActivate;
                        phase_q    <= PhLaunch;
                    end
                end
                StSel: begin
                    hart_q          <= sel_idx;
                    mask_q[sel_idx] <= 1'b0;
                    state_q         <= StHalt;
                    phase_q         <= PhLaunch;
                end
                default: begin
                    case (phase_q)
                        PhLaunch: begin
                            req_valid_q <= 1'b1;
                            req_addr_q  <= cmd_addr;
                            req_op_q    <= cmd_op;
                            req_data_q  <= cmd_data;
                            phase_q     <= PhReq;
                        end
                        PhReq: begin
                            if (dmi_req_ready_i) begin
                                req_valid_q  <= 1'b0;
                                resp_ready_q <= 1'b1;
                                phase_q      <= PhResp;
                            end
                        end
                        PhResp: begin
                            if (dmi_resp_valid_i) begin
                                resp_ready_q <= 1'b0;
                                if (fail_code != 3'd0) begin
                                    state_q    <= StError;
                                    error_q    <= 1'b1;
                                    busy_q     <= 1'b0;
                                    err_code_q <= fail_code;
                                    err_hart_q <= 10'(hart_q);
                                end else if (reissue) begin
                                    busy_cnt_q  <= busy_cnt_q + BusyW'(1);
                                    req_valid_q <= 1'b1;
                                    phase_q     <= PhReq;
                                end else if (poll_retry) begin
                                    busy_cnt_q  <= '0;
                                    poll_cnt_q  <= poll_cnt_q + PollW'(1);
                                    req_valid_q <= 1'b1;
                                    phase_q     <= PhReq;
                                end else begin
                                    busy_cnt_q <= '0;
                                    poll_cnt_q <= '0;
                                    phase_q    <= PhLaunch;
                                    if (adv_state == StSel && !sel_any) begin
                                        state_q <= StDone;
                                        done_q  <= 1'b1;
                                        busy_q  <= 1'b0;
                                    end else begin
                                        state_q <= adv_state;
                                    end
                                end
                            end
                        end
                        default: phase_q <= PhLaunch;
                    endcase
                end
            endcase
        end
    end

    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign err_hart_o       = err_hart_q;
    assign err_code_o       = err_code_q;

endmodule
